// File: rtl/debug_ocimem_ctrl.sv
// Debug on-chip monitor memory controller: turns JTAG command strobes from the
// debug slave wrapper into monitor RAM accesses and arbitrates with the CPU's debug Avalon slave.
module debug_ocimem_ctrl #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    input  logic              avs_debugaccess,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_JRD,
        S_JCAP,
        S_JWR,
        S_CRD,
        S_CDAT,
        S_CWR
    } state_e;

    state_e              state_q, state_d;
    logic                pend_q, pend_wr_q;
    logic [DATA_W-1:0]   pend_data_q;
    logic [ADDR_W-1:0]   jaddr_q;
    logic [DATA_W-1:0]   mon_dreg_q, rdata_q;
    logic                mon_ready_q, mon_err_q, wait_q;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                str_a, str_na, str_b, str_any, accept, drop;
    logic                ram_we, ram_re, cpu_bad_wr;
    logic [3:0]          ram_be;
    logic [ADDR_W-1:0]   ram_waddr, ram_raddr;
    logic [DATA_W-1:0]   ram_wdata;

    // Only payload bits [35:3] carry meaning for this block
    logic                unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    // Strobe priority: action_a > no_action_a > action_b
    assign str_a   = take_action_ocimem_a;
    assign str_na  = !take_action_ocimem_a && take_no_action_ocimem_a;
    assign str_b   = !take_action_ocimem_a && !take_no_action_ocimem_a && take_action_ocimem_b;
    assign str_any = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign accept  = str_any && !pend_q;
    assign drop    = str_any && pend_q;

    assign cpu_bad_wr = (state_q == S_CWR) && !avs_debugaccess;

    // Next-state and RAM port control
    always_comb begin
        state_d   = state_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_be    = 4'h0;
        ram_waddr = jaddr_q;
        ram_raddr = jaddr_q;
        ram_wdata = pend_data_q;
        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    state_d = pend_wr_q ? S_JWR : S_JRD;
                end else if (accept) begin
                    state_d = str_b ? S_JWR : S_JRD;
                end else if (avs_read) begin
                    state_d = S_CRD;
                end else if (avs_write) begin
                    state_d = S_CWR;
                end
            end
            S_JRD: begin
                ram_re  = 1'b1;
                state_d = S_JCAP;
            end
            S_JCAP: state_d = S_IDLE;
            S_JWR: begin
                ram_we  = 1'b1;
                ram_be  = 4'hF;
                state_d = S_IDLE;
            end
            S_CRD: begin
                ram_re    = 1'b1;
                ram_raddr = avs_address;
                state_d   = S_CDAT;
            end
            S_CDAT: state_d = S_IDLE;
            S_CWR: begin
                ram_we    = avs_debugaccess;
                ram_be    = avs_byteenable;
                ram_waddr = avs_address;
                ram_wdata = avs_writedata;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Monitor RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) begin
                    mem_q[ram_waddr][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pend_q      <= 1'b0;
            pend_wr_q   <= 1'b0;
            pend_data_q <= '0;
            jaddr_q     <= '0;
            mon_dreg_q  <= '0;
            rdata_q     <= '0;
            mon_ready_q <= 1'b0;
            mon_err_q   <= 1'b0;
            wait_q      <= 1'b1;
        end else begin
            state_q <= state_d;

            if (accept) begin
                pend_q      <= 1'b1;
                pend_wr_q   <= str_b;
                pend_data_q <= jdo[34:3];
            end else if (state_q == S_JCAP || state_q == S_JWR) begin
                pend_q <= 1'b0;
            end

            // Reads move jaddr when the command lands; writes post-increment after the RAM write
            if (accept && str_a) begin
                jaddr_q <= jdo[17 +: ADDR_W];
            end else if ((accept && str_na) || state_q == S_JWR) begin
                jaddr_q <= jaddr_q + ADDR_W'(1);
            end

            if (ram_re) begin
                rdata_q <= mem_q[ram_raddr];
            end

            if (state_q == S_JCAP) begin
                mon_dreg_q <= rdata_q;
            end

            if (str_any) begin
                mon_ready_q <= 1'b0;
            end else if (state_q == S_JCAP) begin
                mon_ready_q <= 1'b1;
            end

            if (accept && str_a && jdo[35]) begin
                mon_err_q <= 1'b0;
            end else if (drop || cpu_bad_wr) begin
                mon_err_q <= 1'b1;
            end

            wait_q <= !(state_d == S_CDAT || state_d == S_CWR);
        end
    end

    assign MonDReg         = mon_dreg_q;
    assign monitor_ready   = mon_ready_q;
    assign monitor_error   = mon_err_q;
    assign avs_readdata    = rdata_q;
    assign avs_waitrequest = wait_q;

endmodule

// File: tb/tb_debug_ocimem_ctrl.sv
// Bench for debug_ocimem_ctrl: directed scenarios plus random JTAG/CPU traffic
// compared against a word-array model of the monitor RAM, jaddr and error flag.
module tb_debug_ocimem_ctrl;

    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 256;

    logic          clk;
    logic          reset_n;
    logic [37:0]   jdo;
    logic          take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
    logic [31:0]   MonDReg;
    logic          monitor_ready, monitor_error;
    logic [AW-1:0] avs_address;
    logic          avs_read, avs_write;
    logic [31:0]   avs_writedata;
    logic [3:0]    avs_byteenable;
    logic          avs_debugaccess;
    logic [31:0]   avs_readdata;
    logic          avs_waitrequest;

    debug_ocimem_ctrl #(.ADDR_W(AW)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_debugaccess         (avs_debugaccess),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model
    logic [31:0] mem_m [DEPTH];
    int          jaddr_m;
    bit          err_m;

    function automatic logic [37:0] mk_a(input logic [7:0] a, input logic clr);
        logic [37:0] j;
        j        = '0;
        j[24:17] = a;
        j[35]    = clr;
        return j;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] d);
        logic [37:0] j;
        j       = '0;
        j[34:3] = d;
        return j;
    endfunction

    function automatic void m_cmd(input int kind, input logic [37:0] j);
        if (kind == 0) begin
            jaddr_m = int'(j[24:17]);
            if (j[35]) err_m = 1'b0;
        end else if (kind == 1) begin
            jaddr_m = (jaddr_m + 1) % DEPTH;
        end else begin
            mem_m[jaddr_m] = j[34:3];
            jaddr_m = (jaddr_m + 1) % DEPTH;
        end
    endfunction

    function automatic void m_cpu_wr(input logic [7:0] a, input logic [31:0] d,
                                     input logic [3:0] be, input bit dbg);
        if (!dbg) begin
            err_m = 1'b1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem_m[a][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic jtag_pulse(input int kind, input logic [37:0] j);
        jdo = j;
        take_action_ocimem_a    = (kind == 0);
        take_no_action_ocimem_a = (kind == 1);
        take_action_ocimem_b    = (kind == 2);
        tick();
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
    endtask

    // JTAG read from idle: sample MonDReg/ready in the third cycle after the strobe
    task automatic jtag_rd(input int kind, input logic [37:0] j,
                           output logic [31:0] d, output logic rdy);
        jtag_pulse(kind, j);
        m_cmd(kind, j);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        d   = MonDReg;
        rdy = monitor_ready;
        tick();
    endtask

    task automatic jtag_wr(input logic [31:0] d);
        jtag_pulse(2, mk_b(d));
        m_cmd(2, mk_b(d));
        tick();
    endtask

    task automatic cpu_access(input bit wr, input logic [7:0] a, input logic [31:0] d,
                              input logic [3:0] be, input bit dbg,
                              output logic [31:0] rd, output int lat);
        avs_address     = a;
        avs_read        = !wr;
        avs_write       = wr;
        avs_writedata   = d;
        avs_byteenable  = be;
        avs_debugaccess = dbg;
        lat = -1;
        rd  = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!avs_waitrequest) begin
                lat = c;
                rd  = avs_readdata;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (lat < 0) begin
            n_checks++;
            $display("FAIL cpu_timeout addr=%0h waitrequest never dropped", a);
        end
        @(posedge clk);
        #1;
        avs_read  = 1'b0;
        avs_write = 1'b0;
        if (wr) m_cpu_wr(a, d, be, dbg);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if ({MonDReg, monitor_ready, monitor_error, avs_readdata, avs_waitrequest} !==
            {32'h0, 1'b0, 1'b0, 32'h0, 1'b1})
            $display("FAIL reset_outputs got mon=%h rdy=%b err=%b rd=%h wait=%b",
                     MonDReg, monitor_ready, monitor_error, avs_readdata, avs_waitrequest);
        else n_pass++;
        tick();
        reset_n = 1'b1;
        jaddr_m = 0;
        err_m   = 1'b0;
        tick();
        @(negedge clk);
        n_checks++;
        if (avs_waitrequest !== 1'b1)
            $display("FAIL idle_waitrequest got %b want 1", avs_waitrequest);
        else n_pass++;
        tick();
    endtask

    task automatic test_jtag_read;
        logic [31:0] rd;
        int          lat;
        cpu_access(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b1, rd, lat);
        n_checks++;
        if (lat !== 1) $display("FAIL cpu_wr_latency got %0d want 1", lat);
        else n_pass++;
        jtag_pulse(0, mk_a(8'h10, 1'b0));
        m_cmd(0, mk_a(8'h10, 1'b0));
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (monitor_ready !== 1'b0) $display("FAIL ready_early got %b want 0", monitor_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({monitor_ready, MonDReg} !== {1'b1, mem_m[8'h10]})
            $display("FAIL jtag_read_t3 got rdy=%b mon=%h want rdy=1 mon=%h",
                     monitor_ready, MonDReg, mem_m[8'h10]);
        else n_pass++;
        tick();
        cpu_access(1'b0, 8'h10, 32'h0, 4'hF, 1'b1, rd, lat);
        n_checks++;
        if ({lat, rd} !== {32'd2, mem_m[8'h10]})
            $display("FAIL cpu_rd got lat=%0d d=%h want lat=2 d=%h", lat, rd, mem_m[8'h10]);
        else n_pass++;
    endtask

    task automatic test_wrap;
        logic [31:0] rd, d;
        logic        rdy;
        int          lat;
        cpu_access(1'b1, 8'h00, 32'h0000A5A5, 4'hF, 1'b1, rd, lat);
        jtag_rd(0, mk_a(8'hFF, 1'b0), d, rdy);
        jtag_rd(1, '0, d, rdy);
        n_checks++;
        if ({rdy, d} !== {1'b1, mem_m[0]})
            $display("FAIL wrap_no_action got rdy=%b d=%h want 1 %h", rdy, d, mem_m[0]);
        else n_pass++;
        jtag_rd(0, mk_a(8'hFF, 1'b0), d, rdy);
        jtag_wr(32'hCAFEF00D);
        jtag_wr(32'h12345678);
        cpu_access(1'b0, 8'hFF, 32'h0, 4'hF, 1'b1, rd, lat);
        n_checks++;
        if (rd !== mem_m[255]) $display("FAIL wrap_wr_ff got %h want %h", rd, mem_m[255]);
        else n_pass++;
        cpu_access(1'b0, 8'h00, 32'h0, 4'hF, 1'b1, rd, lat);
        n_checks++;
        if (rd !== mem_m[0]) $display("FAIL wrap_wr_00 got %h want %h", rd, mem_m[0]);
        else n_pass++;
    endtask

    task automatic test_conflict;
        logic [31:0] rd, mon3;
        logic        rdy3;
        int          lat;
        cpu_access(1'b1, 8'd40, $urandom, 4'hF, 1'b1, rd, lat);
        jdo = mk_a(8'h10, 1'b0);
        m_cmd(0, jdo);
        take_action_ocimem_a = 1'b1;
        avs_address = 8'd40;
        avs_read    = 1'b1;
        lat  = -1;
        rdy3 = 1'b0;
        mon3 = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 3) begin
                rdy3 = monitor_ready;
                mon3 = MonDReg;
            end
            if (!avs_waitrequest) begin
                lat = c;
                rd  = avs_readdata;
                break;
            end
            @(posedge clk);
            #1;
            take_action_ocimem_a = 1'b0;
        end
        tick();
        avs_read = 1'b0;
        // JTAG: JRD, JCAP; back in IDLE at +3 where the CPU read is taken -> CRD, CDAT at +5
        n_checks++;
        if (lat !== 5) $display("FAIL conflict_latency got %0d want 5", lat);
        else n_pass++;
        n_checks++;
        if ({rdy3, mon3} !== {1'b1, mem_m[8'h10]})
            $display("FAIL conflict_jtag got rdy=%b mon=%h want 1 %h", rdy3, mon3, mem_m[8'h10]);
        else n_pass++;
        n_checks++;
        if (rd !== mem_m[40]) $display("FAIL conflict_cpu got %h want %h", rd, mem_m[40]);
        else n_pass++;
    endtask

    task automatic test_byteenable;
        logic [31:0] rd, d;
        logic        rdy;
        int          lat;
        cpu_access(1'b1, 8'd64, 32'hFFFFFFFF, 4'hF, 1'b1, rd, lat);
        cpu_access(1'b1, 8'd64, 32'h11223344, 4'b0101, 1'b1, rd, lat);
        cpu_access(1'b0, 8'd64, 32'h0, 4'hF, 1'b1, rd, lat);
        n_checks++;
        if (rd !== mem_m[64] || rd !== 32'hFF22FF44)
            $display("FAIL byte_mask got %h want %h", rd, mem_m[64]);
        else n_pass++;
        cpu_access(1'b1, 8'd64, 32'h0, 4'hF, 1'b0, rd, lat);
        cpu_access(1'b0, 8'd64, 32'h0, 4'hF, 1'b1, rd, lat);
        @(negedge clk);
        n_checks++;
        if ({rd, monitor_error} !== {mem_m[64], err_m})
            $display("FAIL nodebug_wr got d=%h err=%b want %h %b", rd, monitor_error, mem_m[64], err_m);
        else n_pass++;
        tick();
        jtag_rd(0, mk_a(8'd64, 1'b1), d, rdy);
        n_checks++;
        if ({monitor_error, d} !== {err_m, mem_m[64]})
            $display("FAIL err_clear got err=%b d=%h want %b %h", monitor_error, d, err_m, mem_m[64]);
        else n_pass++;
    endtask

    task automatic test_drop;
        logic [31:0] rd;
        int          lat;
        cpu_access(1'b1, 8'h30, 32'h0BADC0DE, 4'hF, 1'b1, rd, lat);
        jtag_pulse(0, mk_a(8'h30, 1'b0));
        m_cmd(0, mk_a(8'h30, 1'b0));
        jtag_pulse(2, mk_b(32'h5A5A5A5A));
        err_m = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({monitor_ready, MonDReg, monitor_error} !== {1'b1, mem_m[8'h30], err_m})
            $display("FAIL drop_pending got rdy=%b mon=%h err=%b want 1 %h %b",
                     monitor_ready, MonDReg, monitor_error, mem_m[8'h30], err_m);
        else n_pass++;
        tick();
        cpu_access(1'b0, 8'h30, 32'h0, 4'hF, 1'b1, rd, lat);
        n_checks++;
        if (rd !== mem_m[8'h30]) $display("FAIL drop_nowrite got %h want %h", rd, mem_m[8'h30]);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd, d;
        logic        rdy;
        int          lat;
        cpu_access(1'b1, 8'h50, 32'h50505050, 4'hF, 1'b1, rd, lat);
        jtag_pulse(0, mk_a(8'h10, 1'b0));
        reset_n = 1'b0;
        #2;
        n_checks++;
        if ({MonDReg, monitor_ready, monitor_error, avs_readdata, avs_waitrequest} !==
            {32'h0, 1'b0, 1'b0, 32'h0, 1'b1})
            $display("FAIL reset_in_jrd got mon=%h rdy=%b err=%b rd=%h wait=%b",
                     MonDReg, monitor_ready, monitor_error, avs_readdata, avs_waitrequest);
        else n_pass++;
        tick();
        tick();
        reset_n = 1'b1;
        jaddr_m = 0;
        err_m   = 1'b0;
        tick();
        jtag_rd(0, mk_a(8'h50, 1'b0), d, rdy);
        jtag_pulse(2, mk_b(32'hDEAD0050));
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        jaddr_m = 0;
        tick();
        cpu_access(1'b0, 8'h50, 32'h0, 4'hF, 1'b1, rd, lat);
        n_checks++;
        if (rd !== mem_m[8'h50]) $display("FAIL reset_in_jwr got %h want %h", rd, mem_m[8'h50]);
        else n_pass++;
        jtag_rd(0, mk_a(8'h10, 1'b0), d, rdy);
        n_checks++;
        if ({rdy, d} !== {1'b1, mem_m[8'h10]})
            $display("FAIL read_after_reset got rdy=%b d=%h want 1 %h", rdy, d, mem_m[8'h10]);
        else n_pass++;
    endtask

    task automatic test_random;
        logic [31:0] rd, d;
        logic        rdy;
        logic [7:0]  a;
        int          lat, op;
        for (int i = 0; i < DEPTH; i++)
            cpu_access(1'b1, 8'(i), $urandom, 4'hF, 1'b1, rd, lat);
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 4);
            a  = 8'($urandom);
            case (op)
                0: cpu_access(1'b1, a, $urandom, 4'($urandom), $urandom_range(0, 7) != 0, rd, lat);
                1: begin
                    cpu_access(1'b0, a, 32'h0, 4'hF, 1'b1, rd, lat);
                    n_checks++;
                    if ({lat, rd} !== {32'd2, mem_m[a]})
                        $display("FAIL rand_cpu_rd a=%h got lat=%0d d=%h want 2 %h", a, lat, rd, mem_m[a]);
                    else n_pass++;
                end
                2, 3: begin
                    if (op == 2) jtag_rd(0, mk_a(a, 1'($urandom)), d, rdy);
                    else jtag_rd(1, '0, d, rdy);
                    n_checks++;
                    if ({rdy, d} !== {1'b1, mem_m[jaddr_m]})
                        $display("FAIL rand_jtag_rd a=%h got rdy=%b d=%h want 1 %h",
                                 jaddr_m, rdy, d, mem_m[jaddr_m]);
                    else n_pass++;
                end
                default: jtag_wr($urandom);
            endcase
            @(negedge clk);
            n_checks++;
            if (monitor_error !== err_m)
                $display("FAIL rand_err op=%0d got %b want %b", op, monitor_error, err_m);
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n                 = 1'b0;
        jdo                     = '0;
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
        avs_address             = '0;
        avs_read                = 1'b0;
        avs_write               = 1'b0;
        avs_writedata           = '0;
        avs_byteenable          = 4'h0;
        avs_debugaccess         = 1'b1;
        jaddr_m                 = 0;
        err_m                   = 1'b0;
        test_reset();
        test_jtag_read();
        test_wrap();
        test_conflict();
        test_byteenable();
        test_drop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
